// File: rtl/lcd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_ctrl_pkg
//  Description : Shared definitions for the HD44780-style LCD controller:
//                sequencer state encodings, write-timer phases, init_sel
//                command codes and default timing constants (50 MHz clock).
//  Revision    : 1.0 - initial release
// ============================================================================
package lcd_ctrl_pkg;

    // Digit states share a common prefix (4'b10xx) so the digit index is
    // simply the low two bits of the state code.
    typedef enum logic [3:0] {
        ST_POWERUP  = 4'd0,
        ST_FUNC_SET = 4'd1,
        ST_DISP_ON  = 4'd2,
        ST_ENTRY    = 4'd3,
        ST_CLR      = 4'd4,
        ST_IDLE     = 4'd5,
        ST_DIG0     = 4'd8,
        ST_DIG1     = 4'd9,
        ST_DIG2     = 4'd10,
        ST_DIG3     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_SETUP = 3'd1,
        PH_PULSE = 3'd2,
        PH_HOLD  = 3'd3,
        PH_WAIT  = 3'd4
    } phase_t;

    localparam logic [1:0] INIT_CLEAR    = 2'd0;
    localparam logic [1:0] INIT_DISP_ON  = 2'd1;
    localparam logic [1:0] INIT_ENTRY    = 2'd2;
    localparam logic [1:0] INIT_FUNC_SET = 2'd3;

    localparam int unsigned DEF_T_POWERUP = 750000;
    localparam int unsigned DEF_T_SETUP   = 2;
    localparam int unsigned DEF_T_E_HIGH  = 12;
    localparam int unsigned DEF_T_HOLD    = 2;
    localparam int unsigned DEF_T_CMD     = 2000;
    localparam int unsigned DEF_T_CLEAR   = 82000;
    localparam int unsigned DEF_T_REFRESH = 5000000;
    localparam int unsigned DEF_CNT_W     = 24;

    function automatic logic [1:0] digit_of(input state_t s);
        logic [3:0] v;
        v = s;
        return v[1:0];
    endfunction

    function automatic logic is_digit(input state_t s);
        logic [3:0] v;
        v = s;
        return v[3];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_ctrl_write_timer.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_write_timer
//  Description : Times one LCD bus write: SETUP -> PULSE (E high) -> HOLD ->
//                WAIT (long or short post-command delay).
//  Ports       : i_start     - begin a transaction (accepted when idle or on
//                              the final WAIT cycle, allowing back-to-back)
//                i_long_wait - select T_CLEAR instead of T_CMD for the WAIT
//                o_e         - LCD enable strobe
//                o_drive     - datapath drives DB (SETUP..HOLD)
//                o_busy      - transaction in progress (SETUP..WAIT)
//                o_done      - last WAIT cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_write_timer
    import lcd_ctrl_pkg::*;
#(
    parameter int unsigned T_SETUP  = DEF_T_SETUP,
    parameter int unsigned T_E_HIGH = DEF_T_E_HIGH,
    parameter int unsigned T_HOLD   = DEF_T_HOLD,
    parameter int unsigned T_CMD    = DEF_T_CMD,
    parameter int unsigned T_CLEAR  = DEF_T_CLEAR,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_long_wait,
    output logic o_e,
    output logic o_drive,
    output logic o_busy,
    output logic o_done
);

    localparam logic [CNT_W-1:0] c_setup_last = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] c_e_last     = CNT_W'(T_E_HIGH - 1);
    localparam logic [CNT_W-1:0] c_hold_last  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] c_cmd_last   = CNT_W'(T_CMD - 1);
    localparam logic [CNT_W-1:0] c_clear_last = CNT_W'(T_CLEAR - 1);

    phase_t           r_phase;
    phase_t           w_phase_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_long;
    logic [CNT_W-1:0] w_wait_last;

    assign w_wait_last = r_long ? c_clear_last : c_cmd_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_IDLE;
            r_cnt   <= '0;
            r_long  <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            if (i_start) begin
                r_long <= i_long_wait;
            end
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        o_e         = 1'b0;
        o_drive     = 1'b0;
        o_busy      = 1'b1;
        o_done      = 1'b0;
        case (r_phase)
            PH_IDLE: begin
                o_busy    = 1'b0;
                w_cnt_nxt = '0;
                if (i_start) begin
                    w_phase_nxt = PH_SETUP;
                end
            end
            PH_SETUP: begin
                o_drive = 1'b1;
                if (r_cnt == c_setup_last) begin
                    w_phase_nxt = PH_PULSE;
                    w_cnt_nxt   = '0;
                end
            end
            PH_PULSE: begin
                o_drive = 1'b1;
                o_e     = 1'b1;
                if (r_cnt == c_e_last) begin
                    w_phase_nxt = PH_HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            PH_HOLD: begin
                o_drive = 1'b1;
                if (r_cnt == c_hold_last) begin
                    w_phase_nxt = PH_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PH_WAIT: begin
                if (r_cnt == w_wait_last) begin
                    o_done      = 1'b1;
                    w_cnt_nxt   = '0;
                    // A new start on the final WAIT cycle chains directly
                    // into the next SETUP with no idle gap.
                    w_phase_nxt = i_start ? PH_SETUP : PH_IDLE;
                end
            end
            default: begin
                w_phase_nxt = PH_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_ctrl
//  Description : Sequencing FSM for an HD44780-style 8-bit LCD. Runs the
//                power-up init (function set, display on, entry mode, clear)
//                and then refreshes four digits periodically or on request.
//  Ports       : clk, rst (sync, active-high), update (refresh request)
//                init_sel/data_sel/digit_sel/DB_sel - datapath byte selects
//                lcd_e/lcd_rs/lcd_rw - LCD bus control
//                ready (init complete), busy (write/post-wait in progress)
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int unsigned T_POWERUP = DEF_T_POWERUP,
    parameter int unsigned T_SETUP   = DEF_T_SETUP,
    parameter int unsigned T_E_HIGH  = DEF_T_E_HIGH,
    parameter int unsigned T_HOLD    = DEF_T_HOLD,
    parameter int unsigned T_CMD     = DEF_T_CMD,
    parameter int unsigned T_CLEAR   = DEF_T_CLEAR,
    parameter int unsigned T_REFRESH = DEF_T_REFRESH,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       update,
    output logic [1:0] init_sel,
    output logic       data_sel,
    output logic [1:0] digit_sel,
    output logic       DB_sel,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       ready,
    output logic       busy
);

    localparam logic [CNT_W-1:0] c_pwr_last = CNT_W'(T_POWERUP - 1);
    localparam logic [CNT_W-1:0] c_ref_last = CNT_W'(T_REFRESH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;          // power-up delay / refresh interval
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_pending;
    logic             w_pending_nxt;
    logic             r_ready;
    logic             w_start;
    logic             w_long_wait;
    logic             w_done;
    logic             w_entry_done;

    lcd_write_timer #(
        .T_SETUP  (T_SETUP),
        .T_E_HIGH (T_E_HIGH),
        .T_HOLD   (T_HOLD),
        .T_CMD    (T_CMD),
        .T_CLEAR  (T_CLEAR),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_start),
        .i_long_wait (w_long_wait),
        .o_e         (lcd_e),
        .o_drive     (DB_sel),
        .o_busy      (busy),
        .o_done      (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_POWERUP;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pending_nxt;
            if (w_entry_done) begin
                r_ready <= 1'b1;
            end
        end
    end

    // The write timer is started on the same edge the sequencer enters a
    // command state, so the selects below are valid from the first SETUP
    // cycle and never change while a transaction is in flight.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_start       = 1'b0;
        w_pending_nxt = r_pending;
        if (update && (r_state != ST_IDLE)) begin
            w_pending_nxt = 1'b1;
        end
        case (r_state)
            ST_POWERUP: begin
                if (r_cnt == c_pwr_last) begin
                    w_state_nxt = ST_FUNC_SET;
                    w_start     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_FUNC_SET: if (w_done) begin w_state_nxt = ST_DISP_ON; w_start = 1'b1; end
            ST_DISP_ON:  if (w_done) begin w_state_nxt = ST_ENTRY;   w_start = 1'b1; end
            ST_ENTRY:    if (w_done) begin w_state_nxt = ST_CLR;     w_start = 1'b1; end
            ST_CLR:      if (w_done) begin w_state_nxt = ST_DIG0;    w_start = 1'b1; end
            ST_DIG0:     if (w_done) begin w_state_nxt = ST_DIG1;    w_start = 1'b1; end
            ST_DIG1:     if (w_done) begin w_state_nxt = ST_DIG2;    w_start = 1'b1; end
            ST_DIG2:     if (w_done) begin w_state_nxt = ST_DIG3;    w_start = 1'b1; end
            ST_DIG3:     if (w_done) begin w_state_nxt = ST_IDLE; end
            ST_IDLE: begin
                // Timeout, a queued request and a fresh request all collapse
                // into a single frame.
                if ((r_cnt == c_ref_last) || r_pending || update) begin
                    w_state_nxt   = ST_CLR;
                    w_start       = 1'b1;
                    w_pending_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_POWERUP;
            end
        endcase
    end

    assign w_long_wait  = (w_state_nxt == ST_CLR);
    assign w_entry_done = (r_state == ST_ENTRY) && w_done;
    // ready is visible on ENTRY's final WAIT cycle, ahead of the clear.
    assign ready        = r_ready | w_entry_done;
    assign lcd_rw       = 1'b0;

    always_comb begin
        init_sel  = INIT_CLEAR;
        data_sel  = 1'b0;
        digit_sel = 2'd0;
        lcd_rs    = 1'b0;
        case (r_state)
            ST_FUNC_SET: init_sel = INIT_FUNC_SET;
            ST_DISP_ON:  init_sel = INIT_DISP_ON;
            ST_ENTRY:    init_sel = INIT_ENTRY;
            ST_CLR:      init_sel = INIT_CLEAR;
            default: begin
                if (is_digit(r_state)) begin
                    data_sel  = 1'b1;
                    lcd_rs    = 1'b1;
                    digit_sel = digit_of(r_state);
                end
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_ctrl
//  Description : Directed self-checking bench for lcd_ctrl using shortened
//                timing (POWERUP 20, SETUP 2, E 3, HOLD 2, CMD 10, CLEAR 30,
//                REFRESH 100). Cycle n = state after n clock edges with rst low.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       update = 1'b0;
    logic [1:0] init_sel;
    logic       data_sel;
    logic [1:0] digit_sel;
    logic       DB_sel;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       ready;
    logic       busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    lcd_ctrl #(
        .T_POWERUP (20),
        .T_SETUP   (2),
        .T_E_HIGH  (3),
        .T_HOLD    (2),
        .T_CMD     (10),
        .T_CLEAR   (30),
        .T_REFRESH (100),
        .CNT_W     (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .update    (update),
        .init_sel  (init_sel),
        .data_sel  (data_sel),
        .digit_sel (digit_sel),
        .DB_sel    (DB_sel),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .ready     (ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic step_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Waits for the next E pulse, captures the selects at its rise and
    // checks they hold through E high and HOLD, and that DB_sel drops on
    // the first WAIT cycle.
    task automatic next_pulse(input int limit, output int t_rise, output int t_fall,
                              output logic [1:0] isel, output logic [1:0] dig,
                              output logic rs, output logic dsel, output logic good);
        int n = 0;
        good = 1'b1;
        while (lcd_e !== 1'b1 && n < limit) begin @(negedge clk); n++; end
        t_rise = cyc;
        isel = init_sel; dig = digit_sel; rs = lcd_rs; dsel = data_sel;
        if (lcd_e !== 1'b1) good = 1'b0;
        while (lcd_e === 1'b1 && n < limit) begin
            if (init_sel !== isel || digit_sel !== dig || lcd_rs !== rs ||
                data_sel !== dsel || DB_sel !== 1'b1) good = 1'b0;
            @(negedge clk); n++;
        end
        t_fall = cyc;
        for (int h = 0; h < 2; h++) begin
            if (lcd_e !== 1'b0 || DB_sel !== 1'b1 || init_sel !== isel ||
                digit_sel !== dig || lcd_rs !== rs) good = 1'b0;
            @(negedge clk);
        end
        if (DB_sel !== 1'b0 || busy !== 1'b1) good = 1'b0;
    endtask

    // One frame: clear command starting SETUP at cycle t0, then four digits.
    task automatic check_frame(input int t0, input bit inject);
        int n = 0;
        int tr, tf, clr_fall;
        logic [1:0] is, dg;
        logic rs, ds, gd;
        while (DB_sel !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (cyc != t0 || DB_sel !== 1'b1)
            begin fails++; $display("FAIL frame_start: got cycle %0d, expected %0d", cyc, t0); end
        next_pulse(200, tr, tf, is, dg, rs, ds, gd);
        clr_fall = tf;
        checks++;
        if (tr != t0 + 2 || tf - tr != 3)
            begin fails++; $display("FAIL clear_timing: rise %0d fall %0d, expected rise %0d width 3", tr, tf, t0 + 2); end
        checks++;
        if ({is, rs, ds, gd} !== {2'd0, 1'b0, 1'b0, 1'b1})
            begin fails++; $display("FAIL clear_selects: init_sel %0d rs %0b data_sel %0b window %0b, expected 0 0 0 1", is, rs, ds, gd); end
        if (inject) begin
            repeat (3) begin
                update = 1'b1; @(negedge clk);
                update = 1'b0; @(negedge clk);
            end
        end
        for (int d = 0; d < 4; d++) begin
            next_pulse(200, tr, tf, is, dg, rs, ds, gd);
            checks++;
            if (tr != t0 + 39 + 17 * d || tf - tr != 3)
                begin fails++; $display("FAIL digit_timing: digit %0d rise %0d fall %0d, expected rise %0d width 3", d, tr, tf, t0 + 39 + 17 * d); end
            checks++;
            if ({dg, rs, ds, gd} !== {d[1:0], 1'b1, 1'b1, 1'b1})
                begin fails++; $display("FAIL digit_selects: digit %0d got digit_sel %0d rs %0b data_sel %0b window %0b", d, dg, rs, ds, gd); end
            if (d == 0) begin
                checks++;
                if (tr - clr_fall != 34)
                    begin fails++; $display("FAIL clear_gap: got %0d cycles, expected 34", tr - clr_fall); end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({lcd_e, DB_sel, lcd_rs, lcd_rw, ready, busy} !== 6'b0)
            begin fails++; $display("FAIL reset_ctrl: e/db/rs/rw/ready/busy = %b, expected 000000", {lcd_e, DB_sel, lcd_rs, lcd_rw, ready, busy}); end
        checks++;
        if ({init_sel, data_sel, digit_sel} !== 5'b0)
            begin fails++; $display("FAIL reset_sel: init/data/digit = %b, expected 00000", {init_sel, data_sel, digit_sel}); end
        rst = 1'b0;
    endtask

    task automatic test_powerup();
        int n = 0;
        logic noisy = 1'b0;
        while (DB_sel !== 1'b1 && n < 100) begin
            if (lcd_e !== 1'b0 || busy !== 1'b0 || ready !== 1'b0) noisy = 1'b1;
            @(negedge clk); n++;
        end
        checks++;
        if (cyc != 20)
            begin fails++; $display("FAIL powerup_len: first SETUP at cycle %0d, expected 20", cyc); end
        checks++;
        if (noisy)
            begin fails++; $display("FAIL powerup_quiet: E/busy/ready active during power-up, expected 0"); end
        checks++;
        if ({lcd_e, busy, lcd_rs, init_sel} !== {1'b0, 1'b1, 1'b0, 2'd3})
            begin fails++; $display("FAIL func_set_setup: e/busy/rs/init_sel = %b, expected 01011", {lcd_e, busy, lcd_rs, init_sel}); end
    endtask

    task automatic test_init();
        logic [1:0] exp_is [3] = '{2'd3, 2'd1, 2'd2};
        int tr, tf;
        logic [1:0] is, dg;
        logic rs, ds, gd;
        for (int i = 0; i < 3; i++) begin
            next_pulse(200, tr, tf, is, dg, rs, ds, gd);
            checks++;
            if (tr != 22 + 17 * i || tf - tr != 3)
                begin fails++; $display("FAIL init_timing: cmd %0d rise %0d fall %0d, expected rise %0d width 3", i, tr, tf, 22 + 17 * i); end
            checks++;
            if ({is, rs, ds, gd} !== {exp_is[i], 1'b0, 1'b0, 1'b1})
                begin fails++; $display("FAIL init_selects: cmd %0d init_sel %0d rs %0b data_sel %0b window %0b, expected %0d 0 0 1", i, is, rs, ds, gd, exp_is[i]); end
        end
        step_to(69);
        checks++;
        if (ready !== 1'b0)
            begin fails++; $display("FAIL ready_early: ready %b at cycle 69, expected 0", ready); end
        step_to(70);
        checks++;
        if (ready !== 1'b1 || DB_sel !== 1'b0 || busy !== 1'b1)
            begin fails++; $display("FAIL ready_rise: ready/db/busy = %b at cycle 70, expected 101", {ready, DB_sel, busy}); end
    endtask

    task automatic test_idle_refresh();
        step_to(175);
        checks++;
        if (busy !== 1'b1)
            begin fails++; $display("FAIL busy_last_wait: busy %b at cycle 175, expected 1", busy); end
        step_to(176);
        checks++;
        if (busy !== 1'b0 || ready !== 1'b1 || DB_sel !== 1'b0)
            begin fails++; $display("FAIL idle_entry: busy/ready/db = %b at cycle 176, expected 010", {busy, ready, DB_sel}); end
        check_frame(276, 1'b1);
    endtask

    task automatic test_back_to_back();
        check_frame(382, 1'b0);
        check_frame(587, 1'b0);
    endtask

    task automatic test_update_idle();
        step_to(700);
        checks++;
        if (DB_sel !== 1'b0 || busy !== 1'b0)
            begin fails++; $display("FAIL idle_quiet: db/busy = %b at cycle 700, expected 00", {DB_sel, busy}); end
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        checks++;
        if ({DB_sel, lcd_e, busy, init_sel} !== {1'b1, 1'b0, 1'b1, 2'd0} || cyc != 701)
            begin fails++; $display("FAIL update_idle: db/e/busy/init_sel = %b at cycle %0d, expected 10100 at 701", {DB_sel, lcd_e, busy, init_sel}, cyc); end
        check_frame(701, 1'b0);
    endtask

    task automatic test_update_timeout();
        step_to(905);
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        check_frame(906, 1'b0);
        check_frame(1111, 1'b0);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (lcd_e !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        checks++;
        if (lcd_e !== 1'b1)
            begin fails++; $display("FAIL reset_mid_pulse: E %b, expected a pulse within 400 cycles", lcd_e); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({lcd_e, DB_sel, ready, busy} !== 4'b0)
            begin fails++; $display("FAIL reset_mid: e/db/ready/busy = %b, expected 0000", {lcd_e, DB_sel, ready, busy}); end
        rst = 1'b0;
        test_powerup();
        test_init();
        check_frame(71, 1'b0);
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_init();
        check_frame(71, 1'b0);
        test_idle_refresh();
        test_back_to_back();
        test_update_idle();
        test_update_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
`default_nettype wire
